// File: rtl/num_entry_pkg.sv
// Shared types and constants for the front-panel number entry stage.
// Digit helpers treat index 0 as the thousands digit in the top nibble.
package num_entry_pkg;

    typedef enum logic [1:0] {
        EDIT    = 2'd0,
        CONVERT = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam int DIGIT_MAX  = 9;
    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 32;

    localparam logic OP_KM = 1'b1;
    localparam logic OP_MI = 1'b0;

    function automatic logic [3:0] digit_at(input logic [15:0] d, input logic [1:0] i);
        int sh;
        sh = 12 - 4 * int'(i);
        return d[sh +: 4];
    endfunction

    function automatic logic [15:0] digit_set(input logic [15:0] d, input logic [1:0] i,
                                              input logic [3:0] v);
        logic [15:0] r;
        int sh;
        r  = d;
        sh = 12 - 4 * int'(i);
        r[sh +: 4] = v;
        return r;
    endfunction

    function automatic logic [3:0] digit_inc(input logic [3:0] v);
        return (v == 4'(DIGIT_MAX)) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'(DIGIT_MAX) : v - 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes one raw push-button, accepts a new level only after it has been
// stable for DEBOUNCE_CYCLES samples, and emits a one-cycle pulse on accepted presses.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            // Any sample that agrees with the accepted level restarts the stability count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/num_entry.sv
// Operator number entry: debounced buttons edit four BCD digits, enter converts them
// to binary MSD-first over four cycles and presents value/op until out_ack.
module num_entry
    import num_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_next,
    input  logic        btn_enter,
    input  logic        btn_mode,
    input  logic        out_ack,
    output logic [31:0] value,
    output logic        op,
    output logic        value_valid,
    output logic [15:0] digits,
    output logic [1:0]  cursor,
    output logic        op_sel,
    output logic        busy
);
    logic [4:0] raw_btn;
    logic [4:0] pulse;
    logic [4:0] held_unused;

    assign raw_btn = {btn_mode, btn_enter, btn_next, btn_down, btn_up};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_btn[g]),
            .level (held_unused[g]),
            .press (pulse[g])
        );
    end

    logic up_p, down_p, next_p, enter_p, mode_p;
    assign {mode_p, enter_p, next_p, down_p, up_p} = pulse;

    state_t      state, state_next;
    logic [1:0]  idx;
    logic [13:0] acc;
    logic [13:0] acc_next;
    logic [15:0] snap;
    logic        snap_op;
    logic [3:0]  cur_d;

    assign cur_d    = digit_at(digits, cursor);
    assign acc_next = acc * 14'd10 + {10'd0, digit_at(snap, idx)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EDIT;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EDIT:    if (enter_p)       state_next = CONVERT;
            CONVERT: if (idx == 2'd3)   state_next = PRESENT;
            PRESENT: if (out_ack)       state_next = EDIT;
            default:                    state_next = EDIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits  <= '0;
            cursor  <= '0;
            op_sel  <= OP_MI;
            op      <= OP_MI;
            value   <= '0;
            idx     <= '0;
            acc     <= '0;
            snap    <= '0;
            snap_op <= OP_MI;
        end else begin
            case (state)
                EDIT: begin
                    // One action per cycle; lower-priority pulses are dropped.
                    if (enter_p) begin
                        idx     <= '0;
                        acc     <= '0;
                        snap    <= digits;
                        snap_op <= op_sel;
                    end else if (up_p) begin
                        digits <= digit_set(digits, cursor, digit_inc(cur_d));
                    end else if (down_p) begin
                        digits <= digit_set(digits, cursor, digit_dec(cur_d));
                    end else if (next_p) begin
                        cursor <= cursor + 2'd1;
                    end else if (mode_p) begin
                        op_sel <= ~op_sel;
                    end
                end
                CONVERT: begin
                    acc <= acc_next;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        value <= {{(VALUE_W - 14){1'b0}}, acc_next};
                        op    <= snap_op;
                    end
                end
                default: ;
            endcase
        end
    end

    assign value_valid = (state == PRESENT);
    assign busy        = (state != EDIT);

endmodule

// File: tb/tb_num_entry.sv
// Directed bench for num_entry with hand-computed expectations, short debounce window.
module tb_num_entry;
    localparam int D = 4;
    localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, NX = 5'b00100,
                           EN = 5'b01000, MD = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btns = '0;
    logic        out_ack = 1'b0;
    logic [31:0] value;
    logic        op, value_valid, op_sel, busy;
    logic [15:0] digits;
    logic [1:0]  cursor;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    num_entry #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btns[0]),
        .btn_down    (btns[1]),
        .btn_next    (btns[2]),
        .btn_enter   (btns[3]),
        .btn_mode    (btns[4]),
        .out_ack     (out_ack),
        .value       (value),
        .op          (op),
        .value_valid (value_valid),
        .digits      (digits),
        .cursor      (cursor),
        .op_sel      (op_sel),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic press(input logic [4:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            btns = m;
            repeat (12) @(negedge clk);
            btns = '0;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic wait_busy();
        int cnt;
        cnt = 0;
        while (!busy && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("enter_busy", busy, 1);
    endtask

    task automatic do_enter(input logic [31:0] exp_val, input logic exp_op);
        int cnt;
        btns[3] = 1'b1;
        wait_busy();
        cnt = 0;
        while (!value_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("valid_latency", cnt, 4);
        check("value", value, exp_val);
        check("op", op, exp_op);
        btns[3] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        check("ack_valid", value_valid, 0);
        check("ack_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btns = 5'($urandom_range(0, 31));
            @(negedge clk);
        end
        check("rst_value", value, 0);
        check("rst_valid", value_valid, 0);
        check("rst_digits", digits, 0);
        check("rst_cursor", cursor, 0);
        check("rst_opsel", op_sel, 0);
        check("rst_op", op, 0);
        check("rst_busy", busy, 0);
        btns = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_value", value, 0);
        check("idle_digits", digits, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", value_valid, 0);

        // Enter 1234
        press(UP, 1); press(NX, 1); press(UP, 2); press(NX, 1);
        press(UP, 3); press(NX, 1); press(UP, 4);
        check("digits_1234", digits, 32'h1234);
        check("cursor_3", cursor, 3);
        do_enter(32'd1234, 1'b0);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!value_valid || value != 32'd1234) ok = 1'b0;
        end
        check("hold_stable", ok, 1);
        ack();
        check("value_held", value, 32'd1234);

        // Wraps
        press(NX, 1);
        check("cursor_wrap", cursor, 0);
        press(DN, 2);
        check("down_wrap", digits, 32'h9234);
        press(NX, 1); press(DN, 3);
        press(NX, 1); press(DN, 4);
        press(NX, 1); press(DN, 5);
        check("digits_9999", digits, 32'h9999);
        do_enter(32'd9999, 1'b0);
        ack();
        press(UP, 1);
        check("up_wrap", digits, 32'h9990);

        // Bounce on btn_up then a clean hold: one increment only
        btns[0] = 1; repeat (1) @(negedge clk);
        btns[0] = 0; repeat (2) @(negedge clk);
        btns[0] = 1; repeat (2) @(negedge clk);
        btns[0] = 0; repeat (2) @(negedge clk);
        btns[0] = 1; repeat (3) @(negedge clk);
        btns[0] = 0; repeat (1) @(negedge clk);
        btns[0] = 1; repeat (10) @(negedge clk);
        btns[0] = 0; repeat (12) @(negedge clk);
        check("bounce_once", digits, 32'h9991);

        // Mode, ignored presses while presenting, priority
        press(MD, 1);
        check("opsel_on", op_sel, 1);
        do_enter(32'd9991, 1'b1);
        press(MD, 1);
        press(UP, 1);
        check("present_valid", value_valid, 1);
        ack();
        check("present_digits", digits, 32'h9991);
        check("present_opsel", op_sel, 1);
        check("present_op", op, 1);
        press(UP | DN, 1);
        check("up_over_down", digits, 32'h9992);

        // Async reset two cycles into conversion
        btns[3] = 1'b1;
        wait_busy();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_value", value, 0);
        check("arst_valid", value_valid, 0);
        check("arst_digits", digits, 0);
        check("arst_busy", busy, 0);
        check("arst_opsel", op_sel, 0);
        btns = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        press(NX, 3);
        press(UP, 5);
        check("digits_0005", digits, 32'h0005);
        do_enter(32'd5, 1'b0);
        ack();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
